// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder: pops the keyboard FIFO, strips E0/F0 prefixes and tracks held keys.
// Optional build macro KBD_TYPEMATIC_FILTER_EN suppresses auto-repeat makes of already-held keys.
module ps2_scan_decoder #(
  parameter int unsigned PREFIX_TIMEOUT = 2_000_000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_ready,
  output logic        rdn,
  output logic        key_valid,
  output logic [7:0]  key_code,
  output logic        key_ext,
  output logic        key_break,
  output logic [10:0] key_down,
  output logic        kbd_err
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StDecode  = 2'd2;

  localparam int unsigned CntW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(PREFIX_TIMEOUT - 1);

  logic [1:0]      state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic [2:0]      skip_q, skip_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [CntW-1:0] tmo_q, tmo_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [7:0]      code_q, code_d;
  logic            kext_q, kext_d;
  logic            kbrk_q, kbrk_d;
  logic [10:0]     down_q, down_d;

  logic       key_hit;
  logic [3:0] key_idx;
  logic       repeat_make;

  // Map the pending byte plus extension flag onto a held-key bit.
  always_comb begin
    key_hit = 1'b1;
    key_idx = 4'd0;
    if (!ext_q) begin
      case (byte_q)
        8'h1D:   key_idx = 4'd0;
        8'h1C:   key_idx = 4'd1;
        8'h1B:   key_idx = 4'd2;
        8'h23:   key_idx = 4'd3;
        8'h29:   key_idx = 4'd4;
        8'h5A:   key_idx = 4'd9;
        8'h76:   key_idx = 4'd10;
        default: key_hit = 1'b0;
      endcase
    end else begin
      case (byte_q)
        8'h75:   key_idx = 4'd5;
        8'h72:   key_idx = 4'd6;
        8'h6B:   key_idx = 4'd7;
        8'h74:   key_idx = 4'd8;
        default: key_hit = 1'b0;
      endcase
    end
  end

`ifdef KBD_TYPEMATIC_FILTER_EN
  assign repeat_make = key_hit && !brk_q && down_q[key_idx];
`else
  assign repeat_make = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    skip_d  = skip_q;
    ext_d   = ext_q;
    brk_d   = brk_q;
    tmo_d   = '0;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    kext_d  = kext_q;
    kbrk_d  = kbrk_q;
    down_d  = down_q;
    case (state_q)
      StIdle: begin
        if (fifo_ready) begin
          state_d = StCapture;
        end else if (ext_q || brk_q) begin
          if (tmo_q == TmoLast) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      StCapture: begin
        byte_d  = fifo_data;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = StIdle;
        if (skip_q != 3'd0) begin
          skip_d = skip_q - 3'd1;
        end else if (byte_q == 8'hE1) begin
          // Remaining seven bytes of the Pause sequence carry no key state.
          skip_d = 3'd7;
          ext_d  = 1'b0;
          brk_d  = 1'b0;
        end else if (byte_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (byte_q == 8'h00 || byte_q == 8'hFF) begin
          err_d = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else if (byte_q == 8'hAA || byte_q == 8'hFA || byte_q == 8'hEE ||
                     byte_q == 8'hFE) begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else begin
          if (!repeat_make) begin
            valid_d = 1'b1;
            code_d  = byte_q;
            kext_d  = ext_q;
            kbrk_d  = brk_q;
          end
          if (key_hit) begin
            down_d[key_idx] = ~brk_q;
          end
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      byte_q  <= 8'h00;
      skip_q  <= 3'd0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      tmo_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 8'h00;
      kext_q  <= 1'b0;
      kbrk_q  <= 1'b0;
      down_q  <= 11'd0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      skip_q  <= skip_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
      kext_q  <= kext_d;
      kbrk_q  <= kbrk_d;
      down_q  <= down_d;
    end
  end

  // Gated by fifo_ready so a pop is never requested from an empty FIFO.
  assign rdn       = ~((state_q == StCapture) && fifo_ready);
  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_ext   = kext_q;
  assign key_break = kbrk_q;
  assign key_down  = down_q;
  assign kbd_err   = err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: a FIFO model feeds bytes, a monitor checks every event.
module tb_ps2_scan_decoder;
  localparam int unsigned T = 20;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_ready = 1'b0;
  logic        rdn;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        key_ext;
  logic        key_break;
  logic [10:0] key_down;
  logic        kbd_err;

  always #5 clk = ~clk;

  ps2_scan_decoder #(.PREFIX_TIMEOUT(T)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .fifo_data (fifo_data),
    .fifo_ready(fifo_ready),
    .rdn       (rdn),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .key_down  (key_down),
    .kbd_err   (kbd_err)
  );

  typedef struct packed {
    logic [7:0]  code;
    logic        ext;
    logic        brk;
    logic [10:0] down;
  } ev_t;

  ev_t         sb[$];
  ev_t         mon_e;
  logic [7:0]  fifo_q[$];
  logic [10:0] exp_down = 11'd0;
  int checks = 0, errors = 0;
  int pops = 0, err_seen = 0, exp_err = 0, rdn_viol = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  // bit_idx < 0 marks an untracked key.
  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk,
                           input int bit_idx);
    if (bit_idx >= 0) exp_down[bit_idx] = ~brk;
    sb.push_back('{code: code, ext: ext, brk: brk, down: exp_down});
  endtask

  task automatic wait_empty();
    int n = 0;
    while (fifo_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (fifo_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL fifo_drain: %0d bytes left, required 0", fifo_q.size());
      fifo_q.delete();
    end
  endtask

  task automatic drain();
    wait_empty();
    repeat (5) @(posedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdn"}, rdn, 1'b1);
    check({tag, "_key_valid"}, key_valid, 1'b0);
    check({tag, "_key_code"}, key_code, 8'h00);
    check({tag, "_key_ext"}, key_ext, 1'b0);
    check({tag, "_key_break"}, key_break, 1'b0);
    check({tag, "_key_down"}, key_down, 11'd0);
    check({tag, "_kbd_err"}, kbd_err, 1'b0);
  endtask

  // FIFO model: pops after an edge where rdn was low with data present.
  initial begin
    logic pend;
    forever begin
      @(negedge clk);
      pend = !rdn && fifo_ready;
      if (!rdn && !fifo_ready) rdn_viol++;
      @(posedge clk);
      #1;
      if (pend && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        pops++;
      end
      fifo_ready = (fifo_q.size() != 0);
      fifo_data  = fifo_ready ? fifo_q[0] : 8'h00;
    end
  end

  // Monitor: every key_valid must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (kbd_err) err_seen++;
      if (key_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: code %0h ext %0b brk %0b, required no event",
                   key_code, key_ext, key_break);
        end else begin
          mon_e = sb.pop_front();
          check("key_code", key_code, mon_e.code);
          check("key_ext", key_ext, mon_e.ext);
          check("key_break", key_break, mon_e.brk);
          check("key_down", key_down, mon_e.down);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, last, gaps_bad, pops0, n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    clrn = 1'b1;
    repeat (2) @(posedge clk);

    // W press / release
    expect_ev(8'h1D, 1'b0, 1'b0, 0); send(8'h1D);
    expect_ev(8'h1D, 1'b0, 1'b1, 0); send(8'hF0); send(8'h1D);
    drain();

    // Up arrow, then plain 75 which must not touch bit 5
    expect_ev(8'h75, 1'b1, 1'b0, 5); send(8'hE0); send(8'h75);
    expect_ev(8'h75, 1'b1, 1'b1, 5); send(8'hE0); send(8'hF0); send(8'h75);
    expect_ev(8'h75, 1'b0, 1'b0, -1); send(8'h75);
    expect_ev(8'h75, 1'b0, 1'b1, -1); send(8'hF0); send(8'h75);
    // Keypad Enter (E0 5A) is not the tracked Enter
    expect_ev(8'h5A, 1'b1, 1'b0, -1); send(8'hE0); send(8'h5A);
    expect_ev(8'h5A, 1'b1, 1'b1, -1); send(8'hE0); send(8'hF0); send(8'h5A);
    expect_ev(8'h5A, 1'b0, 1'b0, 9); send(8'h5A);
    expect_ev(8'h5A, 1'b0, 1'b1, 9); send(8'hF0); send(8'h5A);
    drain();

    // Pause sequence swallowed, then A press
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    expect_ev(8'h1C, 1'b0, 1'b0, 1); send(8'h1C);
    expect_ev(8'h1C, 1'b0, 1'b1, 1); send(8'hF0); send(8'h1C);
    drain();

    // Status bytes clear prefixes; error bytes pulse kbd_err
    send(8'hF0); send(8'hAA);
    expect_ev(8'h1D, 1'b0, 1'b0, 0); send(8'h1D);
    send(8'hFF); exp_err++;
    send(8'hE0); send(8'h00); exp_err++;
    send(8'hFA); send(8'hEE); send(8'hFE);
    expect_ev(8'h1D, 1'b0, 1'b1, 0); send(8'hF0); send(8'h1D);
    drain();
    check("kbd_err_count", err_seen, exp_err);

    // Stale F0 expires after T idle cycles; T-2 keeps it
    send(8'hF0); wait_empty();
    repeat (T + 1) @(posedge clk);
    expect_ev(8'h29, 1'b0, 1'b0, 4); send(8'h29);
    drain();
    send(8'hF0); wait_empty();
    repeat (T - 2) @(posedge clk);
    expect_ev(8'h29, 1'b0, 1'b1, 4); send(8'h29);
    drain();

    // Back-to-back bytes: one pop per 3 cycles
    pops0 = pops; lows = 0; last = -10; gaps_bad = 0;
    expect_ev(8'h1C, 1'b0, 1'b0, 1); expect_ev(8'h1C, 1'b0, 1'b1, 1);
    send(8'h1C); send(8'hF0); send(8'h1C);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (!rdn) begin
        lows++;
        if (i - last < 3) gaps_bad++;
        last = i;
      end
    end
    drain();
    check("rdn_low_count", lows, 3);
    check("pop_count", pops - pops0, 3);
    check("rdn_gap_violations", gaps_bad, 0);

    // Auto-repeat
`ifdef KBD_TYPEMATIC_FILTER_EN
    expect_ev(8'h1D, 1'b0, 1'b0, 0);
`else
    expect_ev(8'h1D, 1'b0, 1'b0, 0);
    expect_ev(8'h1D, 1'b0, 1'b0, 0);
    expect_ev(8'h1D, 1'b0, 1'b0, 0);
`endif
    send(8'h1D); send(8'h1D); send(8'h1D);
    drain();
    expect_ev(8'h1D, 1'b0, 1'b1, 0); send(8'hF0); send(8'h1D);
    drain();

    // Reset between CAPTURE and DECODE loses the byte
    expect_ev(8'h1B, 1'b0, 1'b0, 2); send(8'h1B);
    drain();
    send(8'h23);
    n = 0;
    @(negedge clk);
    while (rdn && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("capture_seen", n < 50, 1'b1);
    @(posedge clk);
    #2;
    clrn = 1'b0;
    exp_down = 11'd0;
    #1;
    check_reset_vals("midreset");
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    drain();
    check("post_reset_key_down", key_down, 11'd0);

    check("sb_empty", sb.size(), 0);
    check("rdn_without_ready", rdn_viol, 0);
    check("kbd_err_final", err_seen, exp_err);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
